// File: rtl/sd_ram_burst_writer_if.sv
// Byte-stream and MCB write-port bundle for the SD-to-RAM burst writer.
// The writer uses "master"; the byte source and MCB model use "slave".
interface sd_ram_burst_writer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full;
    logic        mem_cmd_empty;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr_full;
    logic        mem_wr_empty;
    logic        mem_wr_underrun;
    logic        mem_wr_error;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        input  mem_cmd_full, mem_cmd_empty,
        output mem_wr_en, mem_wr_data, mem_wr_mask,
        input  mem_wr_full, mem_wr_empty, mem_wr_underrun, mem_wr_error
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        output mem_cmd_full, mem_cmd_empty,
        input  mem_wr_en, mem_wr_data, mem_wr_mask,
        output mem_wr_full, mem_wr_empty, mem_wr_underrun, mem_wr_error
    );
endinterface

// File: rtl/sd_ram_burst_writer.sv
// Packs SD bytes into 32-bit words, fills the MCB write FIFO a burst at a time
// and issues one write command per burst until the whole image is in RAM.
module sd_ram_burst_writer #(
    parameter int          BURST_WORDS = 64,
    parameter int          TOTAL_BYTES = 8192,
    parameter logic [29:0] BASE_ADDR   = 30'h0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       calib_done,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] progress,
    sd_ram_burst_writer_if.master bus
);
    localparam int NUM_BURSTS = TOTAL_BYTES / (4 * BURST_WORDS);
    localparam int WCNT_W     = $clog2(BURST_WORDS + 1);
    localparam int BCNT_W     = $clog2(NUM_BURSTS + 1);
    localparam logic [29:0]       BURST_BYTES = 30'(4 * BURST_WORDS);
    localparam logic [WCNT_W-1:0] WORDS_FULL  = WCNT_W'(BURST_WORDS);
    localparam logic [BCNT_W-1:0] LAST_BURST  = BCNT_W'(NUM_BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_ISSUE, S_DRAIN, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_nxt;
    logic [1:0]          byte_cnt_q;
    logic [23:0]         shift_q;
    logic [WCNT_W-1:0]   word_cnt_q;
    logic [BCNT_W-1:0]   burst_cnt_q;
    logic                cmd_en_q;
    logic                wr_en_q;
    logic [31:0]         wr_data_q;
    logic [29:0]         addr_q;
    logic                fault;
    logic                word_done;
    logic                cmd_fire;
    logic                in_ready_c;
    logic                byte_acc;

    assign fault     = bus.mem_wr_underrun | bus.mem_wr_error;
    assign word_done = (word_cnt_q == WORDS_FULL);
    assign byte_acc  = bus.in_valid & in_ready_c;

    always_comb begin
        state_nxt  = state_q;
        in_ready_c = 1'b0;
        cmd_fire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && calib_done) state_nxt = S_FILL;
            end
            S_FILL: begin
                if (fault) begin
                    state_nxt = S_ERROR;
                end else begin
                    // The cycle that strobes the burst's last word takes no new byte.
                    in_ready_c = !bus.mem_wr_full && !word_done;
                    if (word_done) state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fault) begin
                    state_nxt = S_ERROR;
                end else if (!bus.mem_cmd_full) begin
                    cmd_fire  = 1'b1;
                    state_nxt = (burst_cnt_q == LAST_BURST) ? S_DRAIN : S_FILL;
                end
            end
            S_DRAIN: begin
                // Wait out the final command strobe before trusting the empty flags.
                if (fault) begin
                    state_nxt = S_ERROR;
                end else if (!cmd_en_q && bus.mem_cmd_empty && bus.mem_wr_empty) begin
                    state_nxt = S_DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            progress    <= 8'd0;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            cmd_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 32'd0;
            addr_q      <= BASE_ADDR;
        end else begin
            state_q  <= state_nxt;
            busy     <= (state_nxt == S_FILL) || (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN);
            done     <= (state_nxt == S_DONE);
            error    <= (state_nxt == S_ERROR);
            wr_en_q  <= 1'b0;
            cmd_en_q <= cmd_fire;

            if (byte_acc) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= {shift_q[15:0], bus.in_data};
                if (byte_cnt_q == 2'd3) begin
                    wr_en_q    <= 1'b1;
                    wr_data_q  <= {shift_q, bus.in_data};
                    word_cnt_q <= word_cnt_q + WCNT_W'(1);
                end
            end else if ((state_q == S_FILL) && word_done) begin
                word_cnt_q <= '0;
            end

            if (cmd_fire) burst_cnt_q <= burst_cnt_q + BCNT_W'(1);

            // Address and progress advance once the command strobe has been presented.
            if (cmd_en_q) begin
                addr_q <= addr_q + BURST_BYTES;
                if (progress != 8'hFF) progress <= progress + 8'd1;
            end
        end
    end

    assign bus.in_ready          = in_ready_c;
    assign bus.mem_cmd_en        = cmd_en_q;
    assign bus.mem_cmd_instr     = 3'b000;
    assign bus.mem_cmd_bl        = 6'(BURST_WORDS - 1);
    assign bus.mem_cmd_byte_addr = addr_q;
    assign bus.mem_wr_en         = wr_en_q;
    assign bus.mem_wr_data       = wr_data_q;
    assign bus.mem_wr_mask       = 4'b0000;
endmodule

// File: tb/tb_sd_ram_burst_writer.sv
// Randomised bench for sd_ram_burst_writer: a small-burst instance with a wrapping
// base address and a default-parameter instance, both checked against a byte/word model.
module tb_sd_ram_burst_writer;
    localparam logic [29:0] S_BASE = 30'h3FFF_FFF8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_calib, s_start, s_busy, s_done, s_error;
    logic [7:0] s_prog;
    logic       d_calib, d_start, d_busy, d_done, d_error;
    logic [7:0] d_prog;

    sd_ram_burst_writer_if s_if ();
    sd_ram_burst_writer_if d_if ();

    sd_ram_burst_writer #(.BURST_WORDS(2), .TOTAL_BYTES(16), .BASE_ADDR(S_BASE)) dut_s (
        .clk(clk), .reset_n(reset_n), .calib_done(s_calib), .start(s_start),
        .busy(s_busy), .done(s_done), .error(s_error), .progress(s_prog), .bus(s_if.master)
    );

    sd_ram_burst_writer dut_d (
        .clk(clk), .reset_n(reset_n), .calib_done(d_calib), .start(d_start),
        .busy(d_busy), .done(d_done), .error(d_error), .progress(d_prog), .bus(d_if.master)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  s_stim [0:63];
    logic [7:0]  d_stim [0:8199];
    int          s_idx, d_idx;
    bit          s_pend, d_pend;
    bit          s_last_ready, d_last_ready;
    logic [31:0] s_words [$];
    logic [31:0] d_words [$];
    logic [29:0] s_addrs [$];
    logic [29:0] d_addrs [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: record handshakes for the coming edge, then observe on the falling edge.
    task automatic tick();
        #1;
        s_last_ready = s_if.in_ready;
        d_last_ready = d_if.in_ready;
        s_pend = 1'b0;
        d_pend = 1'b0;
        if (s_if.in_valid && s_if.in_ready) begin
            s_idx++;
            s_pend = (s_idx % 4 == 0);
        end
        if (d_if.in_valid && d_if.in_ready) begin
            d_idx++;
            d_pend = (d_idx % 4 == 0);
        end
        @(negedge clk);
        if (reset_n) begin
            chk("s_wr_latency", {31'd0, s_if.mem_wr_en}, {31'd0, s_pend});
            chk("d_wr_latency", {31'd0, d_if.mem_wr_en}, {31'd0, d_pend});
            if (s_if.mem_wr_en || s_if.mem_cmd_en)
                chk("s_strobe_excl", {31'd0, s_if.mem_wr_en & s_if.mem_cmd_en}, 32'd0);
            if (d_if.mem_wr_en || d_if.mem_cmd_en)
                chk("d_strobe_excl", {31'd0, d_if.mem_wr_en & d_if.mem_cmd_en}, 32'd0);
            if (s_if.mem_wr_en)  s_words.push_back(s_if.mem_wr_data);
            if (d_if.mem_wr_en)  d_words.push_back(d_if.mem_wr_data);
            if (s_if.mem_cmd_en) s_addrs.push_back(s_if.mem_cmd_byte_addr);
            if (d_if.mem_cmd_en) d_addrs.push_back(d_if.mem_cmd_byte_addr);
        end
    endtask

    task automatic idle_inputs();
        s_start = 0; d_start = 0; s_calib = 1; d_calib = 1;
        s_if.in_valid = 0; s_if.in_data = 0; d_if.in_valid = 0; d_if.in_data = 0;
        s_if.mem_cmd_full = 0; s_if.mem_cmd_empty = 1; s_if.mem_wr_full = 0; s_if.mem_wr_empty = 1;
        s_if.mem_wr_underrun = 0; s_if.mem_wr_error = 0;
        d_if.mem_cmd_full = 0; d_if.mem_cmd_empty = 1; d_if.mem_wr_full = 0; d_if.mem_wr_empty = 1;
        d_if.mem_wr_underrun = 0; d_if.mem_wr_error = 0;
    endtask

    task automatic clear_model();
        s_idx = 0; d_idx = 0; s_pend = 0; d_pend = 0;
        s_words.delete(); d_words.delete(); s_addrs.delete(); d_addrs.delete();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        clear_model();
    endtask

    task automatic start_s();
        s_start = 1;
        tick();
        s_start = 0;
        chk("s_busy_after_start", {31'd0, s_busy}, 32'd1);
    endtask

    task automatic run_s(input bit rnd);
        int wstall = 0;
        int cstall = 0;
        int cyc = 0;
        bit wf, cf;
        while (!s_done && !s_error && cyc < 400) begin
            s_if.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_if.in_data  = s_stim[s_idx];
            if (rnd) begin
                wf = ($urandom_range(0, 4) == 0);
                cf = ($urandom_range(0, 2) == 0);
            end else begin
                wf = (s_idx == 5) && (wstall < 5);
                cf = (s_idx >= 8) && (cstall < 12);
            end
            if (wf) wstall++;
            if (cf) cstall++;
            s_if.mem_wr_full  = wf;
            s_if.mem_cmd_full = cf;
            tick();
            if (wf) chk("s_stall_in_ready", {31'd0, s_last_ready}, 32'd0);
            if (cf) chk("s_cmd_full_hold", {31'd0, s_if.mem_cmd_en}, 32'd0);
            cyc++;
        end
        s_if.in_valid = 0; s_if.mem_wr_full = 0; s_if.mem_cmd_full = 0;
    endtask

    task automatic verify_s();
        logic [29:0] a;
        chk("s_done", {31'd0, s_done}, 32'd1);
        chk("s_error", {31'd0, s_error}, 32'd0);
        chk("s_busy_end", {31'd0, s_busy}, 32'd0);
        chk("s_progress", {24'd0, s_prog}, 32'd2);
        chk("s_bytes_taken", s_idx, 32'd16);
        chk("s_nwords", s_words.size(), 32'd4);
        for (int k = 0; k < s_words.size() && k < 4; k++)
            chk($sformatf("s_word%0d", k), s_words[k],
                {s_stim[4*k], s_stim[4*k+1], s_stim[4*k+2], s_stim[4*k+3]});
        chk("s_ncmds", s_addrs.size(), 32'd2);
        for (int k = 0; k < s_addrs.size() && k < 2; k++) begin
            a = S_BASE + 30'(8 * k);
            chk($sformatf("s_addr%0d", k), {2'b00, s_addrs[k]}, {2'b00, a});
        end
    endtask

    initial begin
        int cyc;
        int drain;
        idle_inputs();
        reset_n = 0;
        s_if.in_valid = 1;
        #12;
        // Reset values, checked while reset is still held.
        chk("rst_busy", {31'd0, s_busy}, 32'd0);
        chk("rst_done", {31'd0, s_done}, 32'd0);
        chk("rst_error", {31'd0, s_error}, 32'd0);
        chk("rst_progress", {24'd0, s_prog}, 32'd0);
        chk("rst_in_ready", {31'd0, s_if.in_ready}, 32'd0);
        chk("rst_cmd_en", {31'd0, s_if.mem_cmd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, s_if.mem_wr_en}, 32'd0);
        chk("rst_wr_data", s_if.mem_wr_data, 32'd0);
        chk("rst_addr_s", {2'b00, s_if.mem_cmd_byte_addr}, {2'b00, S_BASE});
        chk("rst_addr_d", {2'b00, d_if.mem_cmd_byte_addr}, 32'd0);
        chk("const_bl_s", {26'd0, s_if.mem_cmd_bl}, 32'd1);
        chk("const_bl_d", {26'd0, d_if.mem_cmd_bl}, 32'd63);
        chk("const_instr", {29'd0, s_if.mem_cmd_instr}, 32'd0);
        chk("const_mask", {28'd0, s_if.mem_wr_mask}, 32'd0);
        @(negedge clk);
        reset_n = 1;
        clear_model();

        // Start is ignored without calibration.
        s_calib = 0;
        s_start = 1;
        tick();
        s_start = 0;
        tick();
        tick();
        chk("nocal_busy", {31'd0, s_busy}, 32'd0);
        chk("nocal_in_ready", {31'd0, s_last_ready}, 32'd0);
        chk("nocal_words", s_words.size(), 32'd0);
        s_calib = 1;
        s_if.in_valid = 0;

        // Directed load: bytes 00..0F with a write-full stall and a command-full stall.
        for (int i = 0; i < 64; i++) s_stim[i] = 8'(i);
        start_s();
        run_s(1'b0);
        verify_s();
        s_start = 1;
        tick();
        s_start = 0;
        tick();
        chk("done_sticky", {31'd0, s_done}, 32'd1);
        chk("done_restart_busy", {31'd0, s_busy}, 32'd0);

        // Randomised small loads.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int i = 0; i < 64; i++) s_stim[i] = 8'($urandom);
            start_s();
            run_s(1'b1);
            verify_s();
        end

        // Write error in ISSUE on the cycle the command FIFO stops being full.
        do_reset();
        for (int i = 0; i < 64; i++) s_stim[i] = 8'($urandom);
        start_s();
        cyc = 0;
        drain = 0;
        while (drain < 4 && cyc < 60) begin
            s_if.in_valid = 1;
            s_if.in_data = s_stim[s_idx];
            s_if.mem_cmd_full = 1;
            tick();
            if (s_idx == 8) drain++;
            cyc++;
        end
        chk("err_setup_bytes", s_idx, 32'd8);
        s_if.mem_cmd_full = 0;
        s_if.mem_wr_error = 1;
        tick();
        chk("err_no_cmd", {31'd0, s_if.mem_cmd_en}, 32'd0);
        chk("err_error", {31'd0, s_error}, 32'd1);
        chk("err_busy", {31'd0, s_busy}, 32'd0);
        s_if.mem_wr_error = 0;
        tick();
        tick();
        chk("err_sticky", {31'd0, s_error}, 32'd1);
        chk("err_in_ready", {31'd0, s_last_ready}, 32'd0);
        chk("err_ncmds", s_addrs.size(), 32'd0);
        s_if.in_valid = 0;

        // Asynchronous reset part-way through the second burst.
        do_reset();
        for (int i = 0; i < 64; i++) s_stim[i] = 8'(i + 8'h40);
        start_s();
        cyc = 0;
        while (s_idx < 10 && cyc < 60) begin
            s_if.in_valid = 1;
            s_if.in_data = s_stim[s_idx];
            tick();
            cyc++;
        end
        chk("mid_progress", {24'd0, s_prog}, 32'd1);
        chk("mid_addr", {2'b00, s_if.mem_cmd_byte_addr}, {2'b00, S_BASE + 30'd8});
        #2;
        reset_n = 0;
        #1;
        chk("arst_busy", {31'd0, s_busy}, 32'd0);
        chk("arst_progress", {24'd0, s_prog}, 32'd0);
        chk("arst_in_ready", {31'd0, s_if.in_ready}, 32'd0);
        chk("arst_wr_data", s_if.mem_wr_data, 32'd0);
        chk("arst_addr", {2'b00, s_if.mem_cmd_byte_addr}, {2'b00, S_BASE});
        chk("arst_flags", {29'd0, s_done, s_error, s_if.mem_cmd_en | s_if.mem_wr_en}, 32'd0);
        @(negedge clk);
        reset_n = 1;
        clear_model();
        repeat (6) tick();
        chk("arst_no_cmd", s_addrs.size(), 32'd0);
        chk("arst_no_word", s_words.size(), 32'd0);
        chk("arst_idle_busy", {31'd0, s_busy}, 32'd0);
        s_if.in_valid = 0;

        // Full-size image on the default instance; done must wait for empty FIFOs.
        do_reset();
        for (int i = 0; i < 8200; i++) d_stim[i] = 8'($urandom);
        d_if.mem_cmd_empty = 0;
        d_start = 1;
        tick();
        d_start = 0;
        chk("d_busy_after_start", {31'd0, d_busy}, 32'd1);
        cyc = 0;
        drain = 0;
        while (!d_done && !d_error && cyc < 20000) begin
            d_if.in_valid = ($urandom_range(0, 9) != 0);
            d_if.in_data = d_stim[d_idx];
            d_if.mem_wr_full = ($urandom_range(0, 19) == 0);
            d_if.mem_cmd_full = ($urandom_range(0, 3) == 0);
            if (d_addrs.size() == 32) drain++;
            d_if.mem_cmd_empty = (drain > 6);
            tick();
            if (d_addrs.size() == 32 && drain <= 6)
                chk("d_done_waits_empty", {31'd0, d_done}, 32'd0);
            cyc++;
        end
        d_if.in_valid = 0;
        chk("d_done", {31'd0, d_done}, 32'd1);
        chk("d_error", {31'd0, d_error}, 32'd0);
        chk("d_busy_end", {31'd0, d_busy}, 32'd0);
        chk("d_progress", {24'd0, d_prog}, 32'd32);
        chk("d_bytes_taken", d_idx, 32'd8192);
        chk("d_nwords", d_words.size(), 32'd2048);
        for (int k = 0; k < d_words.size() && k < 2048; k++)
            if (d_words[k] !== {d_stim[4*k], d_stim[4*k+1], d_stim[4*k+2], d_stim[4*k+3]})
                chk($sformatf("d_word%0d", k), d_words[k],
                    {d_stim[4*k], d_stim[4*k+1], d_stim[4*k+2], d_stim[4*k+3]});
        chk("d_ncmds", d_addrs.size(), 32'd32);
        for (int k = 0; k < d_addrs.size() && k < 32; k++)
            chk($sformatf("d_addr%0d", k), {2'b00, d_addrs[k]}, 32'(256 * k));
        if (d_addrs.size() == 32)
            chk("d_last_addr", {2'b00, d_addrs[31]}, 32'h1F00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
